sdc_wb_regfile: RTL and testbench
=================================

// Module: sdc_wb_regfile
// PURPOSE
//   Wishbone classic slave holding the SD controller register bank; responder side of the config/verify master.
//   Decodes 8-bit byte addresses, applies byte-lane writes and generates ack/err with programmable wait states.
//   Exposes register contents to the SD command/data engines; collects their event flags into maskable interrupts.
// PARAMETERS
//   ACK_WAIT      default 0        extra wait cycles between strobe accept and ack (0..15)
//   CAPABILITIES  default 32'h0    value returned at CAPABILITIES (0x30), read-only
//   BLKSIZE_RST   default 12'h1FF  reset value of BLOCK_SIZE
// PORTS
//   wb_clk            in   1    bus clock
//   reset             in   1    asynchronous, active-high
//   wb_adr_i          in   8    byte address; bits [1:0] ignored
//   wb_dat_i          in   32   write data
//   wb_dat_o          out  32   read data, valid only while wb_ack_o=1, else 0
//   wb_sel_i          in   4    byte lane enables
//   wb_we_i           in   1    1=write
//   wb_cyc_i/wb_stb_i in   1    cycle / strobe
//   wb_ack_o          out  1    single-cycle ack
//   wb_err_o          out  1    single-cycle error (see CONFIGURATION)
//   argument_o        out  32   ARGUMENT 0x00
//   command_o         out  14   COMMAND 0x04
//   data_timeout_o    out  24   0x18
//   control_o         out  2    0x1C
//   cmd_timeout_o     out  24   0x20
//   clk_div_o         out  8    0x24
//   block_size_o      out  12   0x44
//   block_count_o     out  16   0x48
//   dma_addr_o        out  32   0x60
//   cmd_start_o       out  1    1-cycle pulse after a committed ARGUMENT write
//   response_i        in   128  RESPONSE_0..3 (0x08..0x14), read-only; [31:0]=RESPONSE_0
//   response_we_i     in   1    latch response_i into response regs
//   cmd_evt_set_i     in   5    set bits of CMD_EVENT_STATUS (0x34)
//   data_evt_set_i    in   3    set bits of DATA_EVENT_STATUS (0x3C)
//   int_cmd_o         out  1    |(cmd status & CMD_EVENT_ENABLE 0x38)
//   int_data_o        out  1    |(data status & DATA_EVENT_ENABLE 0x40)
// BEHAVIOUR
//   Reset: every output and register 0, except block_size_o=BLKSIZE_RST; FSM -> IDLE.
//   FSM IDLE: cyc&stb -> WAIT (ACK_WAIT>0, counter loaded ACK_WAIT-1) or RESP (ACK_WAIT=0).
//   WAIT: counter decrements; at 0 -> RESP. cyc or stb low -> IDLE, no write, no ack.
//   RESP: ack (or err) high exactly one cycle; write committed at this cycle's edge; -> IDLE.
//   Latency: ack rises ACK_WAIT+1 cycles after first cycle of cyc&stb; min 2 cycles/transfer.
//   Strobe held high across ack = new transfer; address/data resampled in IDLE cycle after ack.
//   Writes: bits[8i+7:8i] updated when sel[i]=1; bits beyond register width dropped; reads zero-extend.
//   Event status write: bit cleared where lane active and written bit=0; 1 leaves bit unchanged.
//   Set input and clearing write in same cycle: set wins.
//   Read-only regs (RESPONSE_*, CAPABILITIES) ignore writes; unmapped reads return 0.
//   response_we_i and bus read same cycle: read returns old value.
//   Interrupt outputs combinational from registered status/enable; no extra latency.
//   Reset asserted mid-transfer: ack/err drop immediately, partial write discarded.
// CONFIGURATION
//   SDC_WB_ERR_EN defined: unmapped address or write to read-only reg ends with wb_err_o, not ack; no state change.
//   Undefined: such accesses ack normally (write ignored, read 0); wb_err_o tied 0.
// STRUCTURE
//   Package sdc_regs_pkg: SDC_ADDR_* localparams (shared with bus master), reset values, FSM state encoding.
//   Sub-module sdc_wb_ack_timer: 4-bit wait-state down-counter with load/abort/done.
// TESTING
//   Write 0x7FFF to 0x18, sel=0111 -> ack 1 cycle later (ACK_WAIT=0); read back 0x00007FFF.
//   ACK_WAIT=3: strobe at cycle 0 -> ack cycle 4; drop stb at cycle 2 -> no ack, reg unchanged.
//   cmd_evt_set_i=5'h11, enable=5'h01 -> int_cmd_o=1; write 0 to 0x34 -> status 0, int_cmd_o=0.
//   Write 0xDEADBEEF to 0x00 sel=0011 -> argument_o=0x0000BEEF; cmd_start_o pulses once.
//   Read 0x50 -> data 0 with ack (macro off) / err=1, ack=0 (SDC_WB_ERR_EN on).
//   Master-style sweep 0x18->0x60 with stb held high: every ack one cycle; all values read back.

Source files
------------

// File: rtl/sdc_regs_pkg.sv
// Shared definitions for the SD controller register bank: register byte
// addresses (also used by the bus master), reset values, bus FSM states
// and the byte-lane merge helper.
package sdc_regs_pkg;

    localparam logic [7:0] SDC_ADDR_ARGUMENT          = 8'h00;
    localparam logic [7:0] SDC_ADDR_COMMAND           = 8'h04;
    localparam logic [7:0] SDC_ADDR_RESPONSE_0        = 8'h08;
    localparam logic [7:0] SDC_ADDR_RESPONSE_1        = 8'h0C;
    localparam logic [7:0] SDC_ADDR_RESPONSE_2        = 8'h10;
    localparam logic [7:0] SDC_ADDR_RESPONSE_3        = 8'h14;
    localparam logic [7:0] SDC_ADDR_DATA_TIMEOUT      = 8'h18;
    localparam logic [7:0] SDC_ADDR_CONTROL           = 8'h1C;
    localparam logic [7:0] SDC_ADDR_CMD_TIMEOUT       = 8'h20;
    localparam logic [7:0] SDC_ADDR_CLK_DIV           = 8'h24;
    localparam logic [7:0] SDC_ADDR_CAPABILITIES      = 8'h30;
    localparam logic [7:0] SDC_ADDR_CMD_EVENT_STATUS  = 8'h34;
    localparam logic [7:0] SDC_ADDR_CMD_EVENT_ENABLE  = 8'h38;
    localparam logic [7:0] SDC_ADDR_DATA_EVENT_STATUS = 8'h3C;
    localparam logic [7:0] SDC_ADDR_DATA_EVENT_ENABLE = 8'h40;
    localparam logic [7:0] SDC_ADDR_BLOCK_SIZE        = 8'h44;
    localparam logic [7:0] SDC_ADDR_BLOCK_COUNT       = 8'h48;
    localparam logic [7:0] SDC_ADDR_DMA_ADDR          = 8'h60;

    // Power-on value of BLOCK_SIZE (512-byte blocks, stored as size-1)
    localparam logic [11:0] SDC_BLKSIZE_RST = 12'h1FF;

    typedef enum logic [1:0] {
        SDC_WB_IDLE = 2'd0,
        SDC_WB_WAIT = 2'd1,
        SDC_WB_RESP = 2'd2
    } sdc_wb_state_e;

    // Replace the byte lanes of oldVal selected by sel with those of newVal
    function automatic logic [31:0] sdc_apply_sel(input logic [31:0] oldVal,
                                                  input logic [31:0] newVal,
                                                  input logic [3:0]  sel);
        logic [31:0] result;
        result = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdc_wb_regfile_if.sv
// Wishbone classic bus bundle between the config/verify master and the
// SD controller register bank. Signal suffixes are from the slave's view.
interface sdc_wb_regfile_if;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/sdc_wb_ack_timer.sv
// Wait-state down-counter for the register bank's bus FSM. Load sets the
// count, abort returns it to zero, done reports an expired count.
module sdc_wb_ack_timer (
    input  logic       wb_clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       abort_i,
    input  logic [3:0] loadVal_i,
    output logic       done_o
);

    logic [3:0] count_q;

    // Count down once per cycle after a load; an abort parks the counter
    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (abort_i) begin
            count_q <= 4'd0;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/sdc_wb_regfile.sv
// SD controller register bank, Wishbone classic slave with programmable
// wait states. Optional macro SDC_WB_ERR_EN: unmapped accesses and writes
// to read-only registers terminate with wb_err_o instead of wb_ack_o.
module sdc_wb_regfile
    import sdc_regs_pkg::*;
#(
    parameter int          ACK_WAIT     = 0,
    parameter logic [31:0] CAPABILITIES = 32'h0,
    parameter logic [11:0] BLKSIZE_RST  = SDC_BLKSIZE_RST
) (
    input  logic            wb_clk,
    input  logic            reset,
    sdc_wb_regfile_if.slave wb,
    output logic [31:0]     argument_o,
    output logic [13:0]     command_o,
    output logic [23:0]     data_timeout_o,
    output logic [1:0]      control_o,
    output logic [23:0]     cmd_timeout_o,
    output logic [7:0]      clk_div_o,
    output logic [11:0]     block_size_o,
    output logic [15:0]     block_count_o,
    output logic [31:0]     dma_addr_o,
    output logic            cmd_start_o,
    input  logic [127:0]    response_i,
    input  logic            response_we_i,
    input  logic [4:0]      cmd_evt_set_i,
    input  logic [2:0]      data_evt_set_i,
    output logic            int_cmd_o,
    output logic            int_data_o
);

    localparam logic [3:0] WAIT_LOAD = (ACK_WAIT > 0) ? 4'(ACK_WAIT - 1) : 4'd0;

    sdc_wb_state_e state_q;
    logic          ack_q, err_q;
    logic          req, accessBad, writeEn;
    logic          timerLoad, timerAbort, timerDone;
    logic [7:0]    addrWord;
    logic [31:0]   readVal, mergedVal;
    logic          unused_adrBits;

    logic [31:0]  argument_q, argument_d;
    logic [13:0]  command_q, command_d;
    logic [127:0] response_q, response_d;
    logic [23:0]  dataTimeout_q, dataTimeout_d;
    logic [1:0]   control_q, control_d;
    logic [23:0]  cmdTimeout_q, cmdTimeout_d;
    logic [7:0]   clkDiv_q, clkDiv_d;
    logic [4:0]   cmdStatus_q, cmdStatus_d, cmdEnable_q, cmdEnable_d, cmdClear;
    logic [2:0]   dataStatus_q, dataStatus_d, dataEnable_q, dataEnable_d, dataClear;
    logic [11:0]  blockSize_q, blockSize_d;
    logic [15:0]  blockCount_q, blockCount_d;
    logic [31:0]  dmaAddr_q, dmaAddr_d;
    logic         cmdStart_q, cmdStart_d;

    assign req            = wb.wb_cyc_i & wb.wb_stb_i;
    assign addrWord       = {wb.wb_adr_i[7:2], 2'b00};
    assign unused_adrBits = ^wb.wb_adr_i[1:0];

    assign timerLoad  = (state_q == SDC_WB_IDLE) && req && (ACK_WAIT > 0);
    assign timerAbort = (state_q == SDC_WB_WAIT) && !req;

    sdc_wb_ack_timer u_ack_timer (
        .wb_clk    (wb_clk),
        .reset     (reset),
        .load_i    (timerLoad),
        .abort_i   (timerAbort),
        .loadVal_i (WAIT_LOAD),
        .done_o    (timerDone)
    );

`ifdef SDC_WB_ERR_EN
    // Flag accesses that must end in an error: unmapped, or writes to read-only
    always_comb begin
        accessBad = 1'b0;
        case (addrWord)
            SDC_ADDR_ARGUMENT, SDC_ADDR_COMMAND, SDC_ADDR_DATA_TIMEOUT,
            SDC_ADDR_CONTROL, SDC_ADDR_CMD_TIMEOUT, SDC_ADDR_CLK_DIV,
            SDC_ADDR_CMD_EVENT_STATUS, SDC_ADDR_CMD_EVENT_ENABLE,
            SDC_ADDR_DATA_EVENT_STATUS, SDC_ADDR_DATA_EVENT_ENABLE,
            SDC_ADDR_BLOCK_SIZE, SDC_ADDR_BLOCK_COUNT, SDC_ADDR_DMA_ADDR:
                accessBad = 1'b0;
            SDC_ADDR_RESPONSE_0, SDC_ADDR_RESPONSE_1, SDC_ADDR_RESPONSE_2,
            SDC_ADDR_RESPONSE_3, SDC_ADDR_CAPABILITIES:
                accessBad = wb.wb_we_i;
            default:
                accessBad = 1'b1;
        endcase
    end
`else
    assign accessBad = 1'b0;
`endif

    // Bus handshake: accept strobe, optionally wait, then one ack/err cycle
    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            state_q <= SDC_WB_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                SDC_WB_IDLE: begin
                    if (req) begin
                        if (ACK_WAIT == 0) begin
                            state_q <= SDC_WB_RESP;
                            ack_q   <= !accessBad;
                            err_q   <= accessBad;
                        end else begin
                            state_q <= SDC_WB_WAIT;
                        end
                    end
                end
                SDC_WB_WAIT: begin
                    if (!req) begin
                        state_q <= SDC_WB_IDLE;
                    end else if (timerDone) begin
                        state_q <= SDC_WB_RESP;
                        ack_q   <= !accessBad;
                        err_q   <= accessBad;
                    end
                end
                default: state_q <= SDC_WB_IDLE;
            endcase
        end
    end

    // Read mux: selected register zero-extended, unmapped words read as 0
    always_comb begin
        readVal = '0;
        case (addrWord)
            SDC_ADDR_ARGUMENT:          readVal = argument_q;
            SDC_ADDR_COMMAND:           readVal = 32'(command_q);
            SDC_ADDR_RESPONSE_0:        readVal = response_q[31:0];
            SDC_ADDR_RESPONSE_1:        readVal = response_q[63:32];
            SDC_ADDR_RESPONSE_2:        readVal = response_q[95:64];
            SDC_ADDR_RESPONSE_3:        readVal = response_q[127:96];
            SDC_ADDR_DATA_TIMEOUT:      readVal = 32'(dataTimeout_q);
            SDC_ADDR_CONTROL:           readVal = 32'(control_q);
            SDC_ADDR_CMD_TIMEOUT:       readVal = 32'(cmdTimeout_q);
            SDC_ADDR_CLK_DIV:           readVal = 32'(clkDiv_q);
            SDC_ADDR_CAPABILITIES:      readVal = CAPABILITIES;
            SDC_ADDR_CMD_EVENT_STATUS:  readVal = 32'(cmdStatus_q);
            SDC_ADDR_CMD_EVENT_ENABLE:  readVal = 32'(cmdEnable_q);
            SDC_ADDR_DATA_EVENT_STATUS: readVal = 32'(dataStatus_q);
            SDC_ADDR_DATA_EVENT_ENABLE: readVal = 32'(dataEnable_q);
            SDC_ADDR_BLOCK_SIZE:        readVal = 32'(blockSize_q);
            SDC_ADDR_BLOCK_COUNT:       readVal = 32'(blockCount_q);
            SDC_ADDR_DMA_ADDR:          readVal = dmaAddr_q;
            default:                    readVal = '0;
        endcase
    end

    assign writeEn   = ack_q & wb.wb_we_i & req;
    assign mergedVal = sdc_apply_sel(readVal, wb.wb_dat_i, wb.wb_sel_i);

    // Next register values: byte-lane writes, clear-on-zero status, event sets
    always_comb begin
        argument_d    = argument_q;
        command_d     = command_q;
        dataTimeout_d = dataTimeout_q;
        control_d     = control_q;
        cmdTimeout_d  = cmdTimeout_q;
        clkDiv_d      = clkDiv_q;
        cmdEnable_d   = cmdEnable_q;
        dataEnable_d  = dataEnable_q;
        blockSize_d   = blockSize_q;
        blockCount_d  = blockCount_q;
        dmaAddr_d     = dmaAddr_q;
        cmdClear      = '0;
        dataClear     = '0;
        if (writeEn) begin
            case (addrWord)
                SDC_ADDR_ARGUMENT:          argument_d    = mergedVal;
                SDC_ADDR_COMMAND:           command_d     = mergedVal[13:0];
                SDC_ADDR_DATA_TIMEOUT:      dataTimeout_d = mergedVal[23:0];
                SDC_ADDR_CONTROL:           control_d     = mergedVal[1:0];
                SDC_ADDR_CMD_TIMEOUT:       cmdTimeout_d  = mergedVal[23:0];
                SDC_ADDR_CLK_DIV:           clkDiv_d      = mergedVal[7:0];
                SDC_ADDR_CMD_EVENT_STATUS:  cmdClear      = {5{wb.wb_sel_i[0]}} & ~wb.wb_dat_i[4:0];
                SDC_ADDR_CMD_EVENT_ENABLE:  cmdEnable_d   = mergedVal[4:0];
                SDC_ADDR_DATA_EVENT_STATUS: dataClear     = {3{wb.wb_sel_i[0]}} & ~wb.wb_dat_i[2:0];
                SDC_ADDR_DATA_EVENT_ENABLE: dataEnable_d  = mergedVal[2:0];
                SDC_ADDR_BLOCK_SIZE:        blockSize_d   = mergedVal[11:0];
                SDC_ADDR_BLOCK_COUNT:       blockCount_d  = mergedVal[15:0];
                SDC_ADDR_DMA_ADDR:          dmaAddr_d     = mergedVal;
                default: ;
            endcase
        end
        cmdStatus_d  = (cmdStatus_q & ~cmdClear) | cmd_evt_set_i;
        dataStatus_d = (dataStatus_q & ~dataClear) | data_evt_set_i;
        response_d   = response_we_i ? response_i : response_q;
        cmdStart_d   = writeEn && (addrWord == SDC_ADDR_ARGUMENT);
    end

    // Register bank storage
    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            argument_q    <= '0;
            command_q     <= '0;
            response_q    <= '0;
            dataTimeout_q <= '0;
            control_q     <= '0;
            cmdTimeout_q  <= '0;
            clkDiv_q      <= '0;
            cmdStatus_q   <= '0;
            cmdEnable_q   <= '0;
            dataStatus_q  <= '0;
            dataEnable_q  <= '0;
            blockSize_q   <= BLKSIZE_RST;
            blockCount_q  <= '0;
            dmaAddr_q     <= '0;
            cmdStart_q    <= 1'b0;
        end else begin
            argument_q    <= argument_d;
            command_q     <= command_d;
            response_q    <= response_d;
            dataTimeout_q <= dataTimeout_d;
            control_q     <= control_d;
            cmdTimeout_q  <= cmdTimeout_d;
            clkDiv_q      <= clkDiv_d;
            cmdStatus_q   <= cmdStatus_d;
            cmdEnable_q   <= cmdEnable_d;
            dataStatus_q  <= dataStatus_d;
            dataEnable_q  <= dataEnable_d;
            blockSize_q   <= blockSize_d;
            blockCount_q  <= blockCount_d;
            dmaAddr_q     <= dmaAddr_d;
            cmdStart_q    <= cmdStart_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = ack_q ? readVal : 32'h0;

    assign argument_o     = argument_q;
    assign command_o      = command_q;
    assign data_timeout_o = dataTimeout_q;
    assign control_o      = control_q;
    assign cmd_timeout_o  = cmdTimeout_q;
    assign clk_div_o      = clkDiv_q;
    assign block_size_o   = blockSize_q;
    assign block_count_o  = blockCount_q;
    assign dma_addr_o     = dmaAddr_q;
    assign cmd_start_o    = cmdStart_q;
    assign int_cmd_o      = |(cmdStatus_q & cmdEnable_q);
    assign int_data_o     = |(dataStatus_q & dataEnable_q);

endmodule

// File: tb/tb_sdc_wb_regfile.sv
// Self-checking bench for sdc_wb_regfile: a zero-wait-state instance for
// the register map and event logic, and a three-wait-state instance for
// ack latency and strobe abort.
module tb_sdc_wb_regfile;
    import sdc_regs_pkg::*;

`ifdef SDC_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        bad;
        logic [31:0] expRd;
    } vec_t;

    logic         wbClk;
    logic         reset;
    logic [127:0] responseIn;
    logic         responseWe;
    logic [4:0]   cmdEvtSet;
    logic [2:0]   dataEvtSet;

    logic [31:0] argument0, dmaAddr0, argument3, dmaAddr3;
    logic [13:0] command0, command3;
    logic [23:0] dataTimeout0, cmdTimeout0, dataTimeout3, cmdTimeout3;
    logic [1:0]  control0, control3;
    logic [7:0]  clkDiv0, clkDiv3;
    logic [11:0] blockSize0, blockSize3;
    logic [15:0] blockCount0, blockCount3;
    logic        cmdStart0, intCmd0, intData0, cmdStart3, intCmd3, intData3;

    int checks = 0;
    int fails  = 0;
    int startPulses = 0;

    sdc_wb_regfile_if bus0 ();
    sdc_wb_regfile_if bus3 ();

    sdc_wb_regfile #(.ACK_WAIT(0), .CAPABILITIES(32'hC0FFEE01)) dut0 (
        .wb_clk(wbClk), .reset(reset), .wb(bus0.slave),
        .argument_o(argument0), .command_o(command0), .data_timeout_o(dataTimeout0),
        .control_o(control0), .cmd_timeout_o(cmdTimeout0), .clk_div_o(clkDiv0),
        .block_size_o(blockSize0), .block_count_o(blockCount0), .dma_addr_o(dmaAddr0),
        .cmd_start_o(cmdStart0), .response_i(responseIn), .response_we_i(responseWe),
        .cmd_evt_set_i(cmdEvtSet), .data_evt_set_i(dataEvtSet),
        .int_cmd_o(intCmd0), .int_data_o(intData0)
    );

    sdc_wb_regfile #(.ACK_WAIT(3)) dut3 (
        .wb_clk(wbClk), .reset(reset), .wb(bus3.slave),
        .argument_o(argument3), .command_o(command3), .data_timeout_o(dataTimeout3),
        .control_o(control3), .cmd_timeout_o(cmdTimeout3), .clk_div_o(clkDiv3),
        .block_size_o(blockSize3), .block_count_o(blockCount3), .dma_addr_o(dmaAddr3),
        .cmd_start_o(cmdStart3), .response_i(responseIn), .response_we_i(responseWe),
        .cmd_evt_set_i(cmdEvtSet), .data_evt_set_i(dataEvtSet),
        .int_cmd_o(intCmd3), .int_data_o(intData3)
    );

    initial wbClk = 1'b0;
    always #5 wbClk = ~wbClk;

    // Count command-start pulses seen on the zero-wait instance
    always @(negedge wbClk) begin
        if (cmdStart0) startPulses++;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transfer on the zero-wait bus; returns data, err and ack latency
    task automatic applyStimulus(input logic [7:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic we,
                                 output logic [31:0] rdat, output logic gotErr, output int lat);
        lat = 0;
        @(posedge wbClk); #1;
        bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_sel_i = sel;
        bus0.wb_we_i = we; bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        do begin
            @(posedge wbClk); #1;
            lat++;
        end while (!(bus0.wb_ack_o || bus0.wb_err_o) && lat < 40);
        rdat   = bus0.wb_dat_o;
        gotErr = bus0.wb_err_o;
        @(posedge wbClk); #1;
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
    endtask

    task automatic pulseEvents(input logic [4:0] cmdSet, input logic [2:0] dataSet);
        @(posedge wbClk); #1;
        cmdEvtSet = cmdSet; dataEvtSet = dataSet;
        @(posedge wbClk); #1;
        cmdEvtSet = '0; dataEvtSet = '0;
    endtask

    vec_t        vecs [28];
    logic [7:0]  sweepAdr [7];
    logic [31:0] sweepDat [7];
    logic [31:0] sweepExp [7];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulsesBefore;
        logic        ackSeen;

        vecs[0]  = '{8'h44, 32'h0,        4'hF, 1'b0, 1'b0, 32'h000001FF};
        vecs[1]  = '{8'h00, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000};
        vecs[2]  = '{8'h18, 32'h00007FFF, 4'h7, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{8'h18, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00007FFF};
        vecs[4]  = '{8'h18, 32'hAABBCCDD, 4'h8, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{8'h18, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00007FFF};
        vecs[6]  = '{8'h1C, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{8'h1C, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000003};
        vecs[8]  = '{8'h04, 32'hFFFFFFFF, 4'h1, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{8'h04, 32'h12345678, 4'h2, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{8'h04, 32'h0,        4'hF, 1'b0, 1'b0, 32'h000016FF};
        vecs[11] = '{8'h24, 32'h000000A5, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{8'h24, 32'h0,        4'hF, 1'b0, 1'b0, 32'h000000A5};
        vecs[13] = '{8'h44, 32'h00000ABC, 4'h1, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{8'h44, 32'h0,        4'hF, 1'b0, 1'b0, 32'h000001BC};
        vecs[15] = '{8'h30, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h0};
        vecs[16] = '{8'h30, 32'h0,        4'hF, 1'b0, 1'b0, 32'hC0FFEE01};
        vecs[17] = '{8'h50, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00000000};
        vecs[18] = '{8'h48, 32'hBEEF1234, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[19] = '{8'h48, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00001234};
        vecs[20] = '{8'h60, 32'hDEADBEEF, 4'hC, 1'b1, 1'b0, 32'h0};
        vecs[21] = '{8'h63, 32'h0,        4'hF, 1'b0, 1'b0, 32'hDEAD0000};
        vecs[22] = '{8'h08, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000};
        vecs[23] = '{8'h2C, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0};
        vecs[24] = '{8'h2C, 32'h0,        4'hF, 1'b0, 1'b1, 32'h00000000};
        vecs[25] = '{8'h0C, 32'h00000055, 4'hF, 1'b1, 1'b1, 32'h0};
        vecs[26] = '{8'h0C, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000};
        vecs[27] = '{8'h1C, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000003};

        sweepAdr[0] = 8'h18; sweepDat[0] = 32'h01234567; sweepExp[0] = 32'h00234567;
        sweepAdr[1] = 8'h1C; sweepDat[1] = 32'h89ABCDEE; sweepExp[1] = 32'h00000002;
        sweepAdr[2] = 8'h20; sweepDat[2] = 32'h00FEDCBA; sweepExp[2] = 32'h00FEDCBA;
        sweepAdr[3] = 8'h24; sweepDat[3] = 32'h0000005A; sweepExp[3] = 32'h0000005A;
        sweepAdr[4] = 8'h44; sweepDat[4] = 32'h00000F0F; sweepExp[4] = 32'h00000F0F;
        sweepAdr[5] = 8'h48; sweepDat[5] = 32'h0000C3C3; sweepExp[5] = 32'h0000C3C3;
        sweepAdr[6] = 8'h60; sweepDat[6] = 32'h87654321; sweepExp[6] = 32'h87654321;

        reset = 1'b1;
        responseIn = '0; responseWe = 1'b0; cmdEvtSet = '0; dataEvtSet = '0;
        bus0.wb_adr_i = '0; bus0.wb_dat_i = '0; bus0.wb_sel_i = '0;
        bus0.wb_we_i = 1'b0; bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0;
        bus3.wb_adr_i = '0; bus3.wb_dat_i = '0; bus3.wb_sel_i = '0;
        bus3.wb_we_i = 1'b0; bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0;

        repeat (3) @(posedge wbClk);
        #1;
        checkOutput("rstAck", 32'(bus0.wb_ack_o), 32'h0);
        checkOutput("rstErr", 32'(bus0.wb_err_o), 32'h0);
        checkOutput("rstDat", bus0.wb_dat_o, 32'h0);
        checkOutput("rstBlockSize", 32'(blockSize0), 32'h1FF);
        checkOutput("rstArgument", argument0, 32'h0);
        checkOutput("rstInt", 32'({intCmd0, intData0}), 32'h0);
        @(negedge wbClk);
        reset = 1'b0;
        $display("[TB] reset released, running register-map vectors");

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, rd, er, lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(ERR_EN & vecs[i].bad));
            if (!vecs[i].we) begin
                checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            end
        end
        checkOutput("portDataTimeout", 32'(dataTimeout0), 32'h00007FFF);
        checkOutput("portCommand", 32'(command0), 32'h000016FF);
        checkOutput("portBlockCount", 32'(blockCount0), 32'h00001234);
        checkOutput("portDmaAddr", dmaAddr0, 32'hDEAD0000);
        checkOutput("noStartYet", 32'(startPulses), 32'd0);

        // ARGUMENT write with two lanes, followed by a single start pulse
        pulsesBefore = startPulses;
        applyStimulus(8'h00, 32'hDEADBEEF, 4'h3, 1'b1, rd, er, lat);
        repeat (3) @(posedge wbClk);
        #1;
        checkOutput("argumentLanes", argument0, 32'h0000BEEF);
        checkOutput("cmdStartOnce", 32'(startPulses - pulsesBefore), 32'd1);

        // Command events, enable masking, clear-on-zero and set-wins
        pulseEvents(5'h11, 3'b000);
        applyStimulus(8'h38, 32'h00000001, 4'hF, 1'b1, rd, er, lat);
        #1;
        checkOutput("intCmdSet", 32'(intCmd0), 32'h1);
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("cmdStatusRead", rd, 32'h00000011);
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b1, rd, er, lat);
        #1;
        checkOutput("intCmdCleared", 32'(intCmd0), 32'h0);
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("cmdStatusCleared", rd, 32'h0);
        cmdEvtSet = 5'h10;
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b1, rd, er, lat);
        cmdEvtSet = 5'h00;
        applyStimulus(8'h34, 32'h0, 4'h0, 1'b1, rd, er, lat);
        applyStimulus(8'h34, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("setWinsOverClear", rd, 32'h00000010);
        checkOutput("intCmdMasked", 32'(intCmd0), 32'h0);

        // Data events: write-one keeps, write-zero clears
        pulseEvents(5'h00, 3'b101);
        applyStimulus(8'h40, 32'h00000004, 4'hF, 1'b1, rd, er, lat);
        #1;
        checkOutput("intDataSet", 32'(intData0), 32'h1);
        applyStimulus(8'h3C, 32'hFFFFFFFB, 4'h1, 1'b1, rd, er, lat);
        #1;
        checkOutput("intDataCleared", 32'(intData0), 32'h0);
        applyStimulus(8'h3C, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("dataStatusRead", rd, 32'h00000001);

        // Response capture, and a read racing a capture sees the old word
        @(posedge wbClk); #1;
        responseIn = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        responseWe = 1'b1;
        @(posedge wbClk); #1;
        responseWe = 1'b0;
        applyStimulus(8'h08, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("response0", rd, 32'h11111111);
        applyStimulus(8'h14, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("response3", rd, 32'h44444444);
        @(posedge wbClk); #1;
        bus0.wb_adr_i = 8'h0C; bus0.wb_we_i = 1'b0; bus0.wb_sel_i = 4'hF;
        bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        @(posedge wbClk); #1;
        responseIn = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        responseWe = 1'b1;
        checkOutput("raceAck", 32'(bus0.wb_ack_o), 32'h1);
        checkOutput("raceOldData", bus0.wb_dat_o, 32'h22222222);
        @(posedge wbClk); #1;
        responseWe = 1'b0;
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0;
        applyStimulus(8'h0C, 32'h0, 4'hF, 1'b0, rd, er, lat);
        checkOutput("raceNewData", rd, 32'hBBBBBBBB);

        // Master-style sweep with strobe held high across every ack
        $display("[TB] back-to-back sweep");
        @(posedge wbClk); #1;
        for (int k = 0; k < 14; k++) begin
            bus0.wb_adr_i = sweepAdr[k % 7]; bus0.wb_dat_i = sweepDat[k % 7];
            bus0.wb_sel_i = 4'hF; bus0.wb_we_i = (k < 7);
            bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
            @(posedge wbClk); #1;
            checkOutput($sformatf("sweep%0d_ack", k), 32'(bus0.wb_ack_o), 32'h1);
            if (k >= 7) begin
                checkOutput($sformatf("sweep%0d_rdata", k), bus0.wb_dat_o, sweepExp[k % 7]);
            end
            @(posedge wbClk); #1;
            checkOutput($sformatf("sweep%0d_gap", k), 32'(bus0.wb_ack_o), 32'h0);
        end
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
        checkOutput("sweepCmdTimeout", 32'(cmdTimeout0), 32'h00FEDCBA);
        checkOutput("sweepControl", 32'(control0), 32'h2);

        // Three wait states: ack four cycles after strobe, then an aborted write
        $display("[TB] wait-state instance");
        @(posedge wbClk); #1;
        bus3.wb_adr_i = 8'h1C; bus3.wb_dat_i = 32'h3; bus3.wb_sel_i = 4'hF;
        bus3.wb_we_i = 1'b1; bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge wbClk); #1;
            lat++;
        end while (!bus3.wb_ack_o && lat < 40);
        checkOutput("wait3Latency", 32'(lat), 32'd4);
        @(posedge wbClk); #1;
        bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0; bus3.wb_we_i = 1'b0;
        checkOutput("wait3Write", 32'(control3), 32'h3);
        @(posedge wbClk); #1;
        bus3.wb_dat_i = 32'h0; bus3.wb_we_i = 1'b1;
        bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1;
        ackSeen = 1'b0;
        repeat (2) begin
            @(posedge wbClk); #1;
            if (bus3.wb_ack_o) ackSeen = 1'b1;
        end
        bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0; bus3.wb_we_i = 1'b0;
        repeat (8) begin
            @(posedge wbClk); #1;
            if (bus3.wb_ack_o) ackSeen = 1'b1;
        end
        checkOutput("abortNoAck", 32'(ackSeen), 32'h0);
        checkOutput("abortNoWrite", 32'(control3), 32'h3);
        bus3.wb_adr_i = 8'h1C; bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge wbClk); #1;
            lat++;
        end while (!bus3.wb_ack_o && lat < 40);
        checkOutput("afterAbortLatency", 32'(lat), 32'd4);
        checkOutput("afterAbortRead", bus3.wb_dat_o, 32'h3);
        @(posedge wbClk); #1;
        bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0;

        // Reset landing in the ack cycle of a write
        @(posedge wbClk); #1;
        bus0.wb_adr_i = 8'h24; bus0.wb_dat_i = 32'hFF; bus0.wb_sel_i = 4'hF;
        bus0.wb_we_i = 1'b1; bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        @(posedge wbClk); #1;
        checkOutput("preResetAck", 32'(bus0.wb_ack_o), 32'h1);
        reset = 1'b1;
        #1;
        checkOutput("resetDropsAck", 32'(bus0.wb_ack_o), 32'h0);
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
        @(posedge wbClk); #1;
        reset = 1'b0;
        @(posedge wbClk); #1;
        checkOutput("resetDiscardsWrite", 32'(clkDiv0), 32'h0);
        checkOutput("resetBlockSize", 32'(blockSize0), 32'h1FF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
